// File: rtl/neuron_mac.sv
// Time-multiplexed fixed-point neuron: act(sum(inputs*weights) + bias) over LANES multipliers per beat.
// Optional macro NEURON_SATURATE_EN: clamp the activated result instead of wrapping it.
module neuron_mac #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned NUM_INPUTS = 16,
  parameter int unsigned LANES      = 4,
  parameter int          ACTIVATION = 1,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [DATA_WIDTH-1:0]          inputs [NUM_INPUTS],
  input  logic                                  weight_we,
  input  logic [$clog2(NUM_INPUTS+1)-1:0]       weight_addr,
  input  logic signed [DATA_WIDTH-1:0]          weight_data,
  output logic signed [DATA_WIDTH-1:0]          out,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy
);

  localparam int unsigned ADDR_W = $clog2(NUM_INPUTS + 1);
  localparam int unsigned BEATS  = NUM_INPUTS / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W  = 2 * DATA_WIDTH + $clog2(NUM_INPUTS) + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  if (ACTIVATION < 0 || ACTIVATION > 2) begin : g_bad_activation
    $fatal(1, "neuron_mac: ACTIVATION must be 0, 1 or 2");
  end
  if (NUM_INPUTS < 1 || LANES < 1 || (NUM_INPUTS % LANES) != 0) begin : g_bad_lanes
    $fatal(1, "neuron_mac: LANES must divide NUM_INPUTS");
  end

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_HOLD} state_e;

  state_e                       state_q, state_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [BEAT_W-1:0]            beat_q, beat_d;
  logic signed [DATA_WIDTH-1:0] out_q, out_d;
  logic signed [DATA_WIDTH-1:0] in_q      [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0] weights_q [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0] bias_q;
  logic                         load_in;
  logic                         wr_en;

  logic signed [DATA_WIDTH-1:0] lane_x [LANES];
  logic signed [DATA_WIDTH-1:0] lane_w [LANES];
  logic signed [PROD_W-1:0]     lane_p [LANES];
  logic signed [ACC_W-1:0]      lane_sum;
  logic signed [ACC_W-1:0]      act_r;
  logic signed [ACC_W-1:0]      act_v;
  logic signed [DATA_WIDTH-1:0] act_res;

  // Per-lane operand select for the current beat, then one multiplier per lane
  always_comb begin
    lane_sum = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      lane_x[j] = '0;
      lane_w[j] = '0;
      for (int b = 0; b < int'(BEATS); b++) begin
        if (beat_q == BEAT_W'(b)) begin
          lane_x[j] = in_q[b*int'(LANES)+j];
          lane_w[j] = weights_q[b*int'(LANES)+j];
        end
      end
      lane_p[j] = lane_x[j] * lane_w[j];
      lane_sum  = lane_sum + ACC_W'(lane_p[j]);
    end
  end

  // Rescale, activate, then reduce to DATA_WIDTH
  always_comb begin
    act_r = acc_q >>> FRAC_BITS;
    act_v = act_r;
    if (ACTIVATION == 1 && act_r[ACC_W-1]) act_v = '0;
    if (ACTIVATION == 2 && act_r[ACC_W-1]) act_v = act_r >>> LEAK_SHIFT;
`ifdef NEURON_SATURATE_EN
    if (act_v > SAT_MAX)      act_res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (act_v < SAT_MIN) act_res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                      act_res = DATA_WIDTH'(act_v);
`else
    act_res = DATA_WIDTH'(act_v);
`endif
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    out_d   = out_q;
    load_in = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load_in = 1'b1;
          acc_d   = ACC_W'(bias_q) <<< FRAC_BITS;
          beat_d  = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d  = acc_q + lane_sum;
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(BEATS - 1)) state_d = S_ACT;
      end
      S_ACT: begin
        out_d   = act_res;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Coefficient writes are only honoured while no computation is in flight
  assign wr_en = weight_we && (state_q == S_IDLE || state_q == S_HOLD);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      beat_q <= '0;
      out_q  <= '0;
      bias_q <= '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        in_q[i]      <= '0;
        weights_q[i] <= '0;
      end
    end else begin
      acc_q  <= acc_d;
      beat_q <= beat_d;
      out_q  <= out_d;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        if (load_in) in_q[i] <= inputs[i];
        if (wr_en && weight_addr == ADDR_W'(i)) weights_q[i] <= weight_data;
      end
      if (wr_en && weight_addr == ADDR_W'(NUM_INPUTS)) bias_q <= weight_data;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q == S_MAC) || (state_q == S_ACT);
  assign in_ready  = (state_q == S_IDLE) && !reset;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: a ReLU and a leaky instance share stimulus and are
// checked against an arithmetic model (vector table, hand sequences, random vectors).
module tb_neuron_mac;

  typedef logic [3:0][15:0] vec4_t;
  typedef struct {
    vec4_t       x;
    vec4_t       w;
    logic [15:0] b;
    int          er;
    int          el;
  } vec_rec_t;

`ifdef NEURON_SATURATE_EN
  localparam int BIG_POS = 32767;
  localparam int BIG_NEG = -32768;
`else
  localparam int BIG_POS = 16384;
  localparam int BIG_NEG = 30720;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic weight_we = 1'b0;
  logic out_ready = 1'b1;
  logic [2:0] weight_addr = '0;
  logic signed [15:0] weight_data = '0;
  logic signed [15:0] in_vec [4];
  logic in_ready_r, in_ready_l, ov_r, ov_l, busy_r, busy_l;
  logic signed [15:0] out_r, out_l;

  int checks = 0;
  int errors = 0;
  vec4_t w_m = '0;
  logic [15:0] b_m = '0;
  vec_rec_t tbl [6];

  always #5 clock = ~clock;

  neuron_mac #(.DATA_WIDTH(16), .FRAC_BITS(8), .NUM_INPUTS(4), .LANES(2),
               .ACTIVATION(1), .LEAK_SHIFT(3)) u_relu (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r),
    .inputs(in_vec), .weight_we(weight_we), .weight_addr(weight_addr),
    .weight_data(weight_data), .out(out_r), .out_valid(ov_r),
    .out_ready(out_ready), .busy(busy_r));

  neuron_mac #(.DATA_WIDTH(16), .FRAC_BITS(8), .NUM_INPUTS(4), .LANES(2),
               .ACTIVATION(2), .LEAK_SHIFT(3)) u_leaky (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_l),
    .inputs(in_vec), .weight_we(weight_we), .weight_addr(weight_addr),
    .weight_data(weight_data), .out(out_l), .out_valid(ov_l),
    .out_ready(out_ready), .busy(busy_l));

  function automatic vec4_t mk4(input int a, input int b, input int c, input int d);
    vec4_t v;
    v[0] = 16'(a); v[1] = 16'(b); v[2] = 16'(c); v[3] = 16'(d);
    return v;
  endfunction

  // Reference: exact dot product, floor rescale, activation, then 16-bit reduction
  function automatic longint model(input vec4_t x, input vec4_t w, input logic [15:0] b,
                                   input int act);
    longint s;
    s = longint'($signed(b)) * 256;
    for (int i = 0; i < 4; i++) s += longint'($signed(x[i])) * longint'($signed(w[i]));
    s = s >>> 8;
    if (act == 1 && s < 0) s = 0;
    if (act == 2 && s < 0) s = s >>> 3;
`ifdef NEURON_SATURATE_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`else
    begin
      logic signed [15:0] t;
      t = 16'(s);
      s = t;
    end
`endif
    return s;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    weight_we = 1'b1; weight_addr = 3'(addr); weight_data = 16'(data);
    @(posedge clock); #1;
    weight_we = 1'b0;
  endtask

  task automatic load_w(input vec4_t w, input logic [15:0] b);
    for (int i = 0; i < 4; i++) wr(i, int'(w[i]));
    wr(4, int'(b));
    w_m = w; b_m = b;
  endtask

  task automatic accept(input vec4_t x);
    for (int i = 0; i < 4; i++) in_vec[i] = x[i];
    in_valid = 1'b1;
    chk("in_ready before accept", longint'(in_ready_r), 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input int n0, input longint er, input longint el);
    int n;
    n = n0;
    while (!ov_r && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk({nm, " latency"}, longint'(n), 3);
    chk({nm, " relu out"}, longint'(out_r), er);
    chk({nm, " leaky out"}, longint'(out_l), el);
    chk({nm, " lockstep valid"}, longint'(ov_l), 1);
    if (out_ready) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec4_t x1, xr, wr_v;
    logic [15:0] br;
    logic ok;
    logic signed [15:0] held;

    tbl[0] = '{mk4(256, 512, 768, 1024), mk4(256, 256, 256, 256), 16'(0), 2560, 2560};
    tbl[1] = '{mk4(256, 512, 768, 1024), mk4(-256, -256, -256, -256), 16'(128), 0, -304};
    tbl[2] = '{mk4(25600, 25600, 25600, 25600), mk4(25600, 25600, 25600, 25600), 16'(0),
               BIG_POS, BIG_POS};
    tbl[3] = '{mk4(0, 0, 0, 0), mk4(256, 256, 256, 256), 16'(-256), 0, -32};
    tbl[4] = '{mk4(1, 0, 0, 0), mk4(-1, -1, -1, -1), 16'(0), 0, -1};
    tbl[5] = '{mk4(25600, 25600, 25600, 25600), mk4(-25600, -25600, -25600, -25600), 16'(0),
               0, BIG_NEG};
    x1 = mk4(256, 512, 768, 1024);
    for (int i = 0; i < 4; i++) in_vec[i] = '0;

    // Reset state
    repeat (2) @(posedge clock); #1;
    chk("reset in_ready", longint'(in_ready_r), 0);
    chk("reset out_valid", longint'(ov_r), 0);
    chk("reset busy", longint'(busy_r), 0);
    chk("reset out", longint'(out_r), 0);
    reset = 1'b0; #1;
    chk("in_ready after release", longint'(in_ready_r), 1);

    // Vector table
    for (int k = 0; k < 6; k++) begin
      load_w(tbl[k].w, tbl[k].b);
      accept(tbl[k].x);
      wait_out($sformatf("vec%0d", k), 0, tbl[k].er, tbl[k].el);
    end

    // Backpressure: result and handshake frozen while out_ready is low
    load_w(mk4(256, 256, 256, 256), 16'(0));
    out_ready = 1'b0;
    accept(x1);
    wait_out("stall", 0, 2560, 2560);
    held = out_r;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      if (!ov_r || out_r != held || in_ready_r || in_ready_l) ok = 1'b0;
    end
    chk("stall stable", longint'(ok), 1);
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("release out_valid", longint'(ov_r), 0);
    chk("release in_ready", longint'(in_ready_r), 1);
    chk("release out held", longint'(out_r), 2560);
    xr = mk4(-256, 0, 0, 0);
    accept(xr);
    wait_out("after stall", 0, model(xr, w_m, b_m, 1), model(xr, w_m, b_m, 2));

    // Writes during MAC/ACT are dropped; the same write in IDLE takes effect
    accept(x1);
    weight_we = 1'b1; weight_addr = 3'd0; weight_data = 16'sd512;
    repeat (3) @(posedge clock);
    #1;
    weight_we = 1'b0;
    wait_out("write in MAC", 3, 2560, 2560);
    wr(0, 512);
    w_m[0] = 16'd512;
    accept(x1);
    wait_out("write in IDLE", 0, 2816, 2816);

    // Bias write on the acceptance edge: old bias used now, new bias next time
    weight_we = 1'b1; weight_addr = 3'd4; weight_data = 16'sd1024;
    accept(x1);
    weight_we = 1'b0;
    wait_out("bias on accept", 0, model(x1, w_m, b_m, 1), model(x1, w_m, b_m, 2));
    b_m = 16'd1024;
    accept(x1);
    wait_out("bias next", 0, 3840, 3840);

    // Random vectors against the model
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++) begin
        wr_v[i] = 16'($urandom);
        xr[i]   = 16'($urandom);
      end
      br = 16'($urandom);
      load_w(wr_v, br);
      accept(xr);
      wait_out($sformatf("rand%0d", k), 0, model(xr, w_m, b_m, 1), model(xr, w_m, b_m, 2));
    end

    // Reset during MAC beat 1 aborts and clears coefficients
    load_w(mk4(256, 256, 256, 256), 16'(0));
    accept(x1);
    wait_out("pre-reset", 0, 2560, 2560);
    accept(x1);
    @(posedge clock); #1;
    chk("busy in MAC", longint'(busy_r), 1);
    reset = 1'b1; #1;
    chk("abort out", longint'(out_r), 0);
    chk("abort out_valid", longint'(ov_r), 0);
    chk("abort busy", longint'(busy_l), 0);
    chk("abort in_ready", longint'(in_ready_l), 0);
    @(posedge clock); #1;
    reset = 1'b0; #1;
    chk("post-abort in_ready", longint'(in_ready_r), 1);
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      if (ov_r || ov_l) ok = 1'b0;
    end
    chk("no valid for aborted vector", longint'(ok), 1);
    w_m = '0; b_m = '0;
    for (int i = 0; i < 4; i++) xr[i] = 16'($urandom);
    accept(xr);
    wait_out("zeroed weights", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Parametrised, time-multiplexed fixed-point neuron. It computes `act(Σ inputs[i]·weights[i] + bias)` using `LANES` parallel multipliers. Weights and bias live in runtime-writable registers. Input and output each use a valid/ready handshake. It is the successor neuron primitive for layer arrays: one instance per neuron, driven by the layer controller.

## Interface
Parameters:
- `DATA_WIDTH`, 16: signed two's-complement width of inputs, weights, bias and out.
- `FRAC_BITS`, 8: fractional bits of the Q format shared by all data.
- `NUM_INPUTS`, 16: number of synapses. Must be ≥ 1.
- `LANES`, 4: multipliers per beat. Must divide `NUM_INPUTS`.
- `ACTIVATION`, 1: activation select.
  - 0 = identity.
  - 1 = ReLU.
  - 2 = leaky ReLU.
  - Any other value is an elaboration `$fatal`.
- `LEAK_SHIFT`, 3: arithmetic right shift applied to negative values in leaky mode.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: `inputs` holds a valid vector.
- `in_ready`, out, 1: block accepts a vector; high only in IDLE.
- `inputs`, in, `DATA_WIDTH` × `NUM_INPUTS`: unpacked signed input vector.
- `weight_we`, in, 1: weight/bias write strobe.
- `weight_addr`, in, `$clog2(NUM_INPUTS+1)`: 0..`NUM_INPUTS`-1 selects a weight; `NUM_INPUTS` selects the bias; other values are ignored.
- `weight_data`, in, `DATA_WIDTH`: signed write data.
- `out`, out, `DATA_WIDTH`: signed activated result.
- `out_valid`, out, 1: `out` is valid; held until `out_ready`.
- `out_ready`, in, 1: downstream accepts `out`.
- `busy`, out, 1: high in MAC or ACT.

## Operation
- FSM states: IDLE, MAC, ACT, HOLD.
  - IDLE: `in_ready`=1. On `in_valid`, the edge captures `inputs` into an internal register, loads `acc` = `bias <<< FRAC_BITS` (sign-extended), clears `beat`, and moves to MAC.
  - MAC: each cycle adds `LANES` products to `acc`.
    - The products are `in_reg[beat*LANES+j]·weights[beat*LANES+j]` for j = 0..`LANES`-1.
    - `beat` increments each cycle.
    - When `beat` == `NUM_INPUTS/LANES`-1, move to ACT.
  - ACT: compute `r = acc >>> FRAC_BITS` (arithmetic shift, truncation toward −∞).
    - Apply the activation:
      - ReLU: `r<0 ? 0 : r`.
      - Leaky: `r<0 ? r >>> LEAK_SHIFT : r`.
    - Reduce `r` to `DATA_WIDTH` bits (see Configuration).
    - Register the result into `out`, then move to HOLD.
  - HOLD: `out_valid`=1. On `out_ready`, move to IDLE. `out` keeps its value after leaving HOLD until the next ACT.
- Accumulator width: `2*DATA_WIDTH + $clog2(NUM_INPUTS) + 1` bits, signed. `acc` never overflows internally.
- Weight/bias writes:
  - Take effect on the edge where `weight_we`=1 and the state is IDLE or HOLD.
  - Writes are silently dropped in MAC or ACT.
  - A write in the same IDLE cycle as an input acceptance is applied, but the load into `acc` on that edge uses the old bias.
- Reset values:
  - `out`=0, `out_valid`=0, `busy`=0, `in_ready`=0 while `reset` is asserted, and 1 after release (IDLE).
  - All weights and the bias are 0.
  - `acc`=0, `beat`=0, state IDLE.
- Reset mid-operation aborts the computation immediately. No `out_valid` is produced for the aborted vector.

## Timing
- Let B = `NUM_INPUTS/LANES`. The acceptance edge is edge 0.
  - MAC occupies edges 1..B.
  - ACT register at edge B+1.
  - `out_valid` is high from edge B+1 onward: latency B+1 cycles.
- Minimum spacing between accepted vectors with `out_ready` tied high: B+3 cycles.
- `in_ready` and `out_valid` are never high simultaneously.
- `out_valid` and `out` are stable while `out_ready`=0.

## Configuration
- `NEURON_SATURATE_EN` defined: an activated result outside [−2^(DW−1), 2^(DW−1)−1] clamps to the nearest bound.
- Not defined: the result wraps; `out` = low `DATA_WIDTH` bits of the activated value.

## Test plan
Setup: `DATA_WIDTH`=16, `FRAC_BITS`=8, `NUM_INPUTS`=4, `LANES`=2. 1.0 = 256.
1. ReLU, weights all 256, bias 0, inputs {256,512,768,1024} → `out`=2560, `out_valid` exactly 3 cycles after acceptance.
2. Weights all −256, bias 128: ReLU → 0; leaky (`LEAK_SHIFT`=3) → (−2560+128)>>>3 = −304.
3. Inputs and weights all 25600: with `NEURON_SATURATE_EN` → 32767; without → 16384.
4. `out_ready` held 0 for 10 cycles → `out_valid`/`out` stable, `in_ready`=0; release → IDLE next cycle, next vector accepted.
5. Weight write to addr 0 (value 512) during MAC → ignored, result unchanged; the same write in IDLE → affects the next result.
6. Assert `reset` during MAC beat 1 → `out`=0, `out_valid`=0, `in_ready`=1 after release, weights read back as 0 (result 0 for any input).
